// File: rtl/keypad_emulator.sv
// Column-driving model of a 4x4 matrix keypad: queued key presses (key + hold)
// close one row-to-column switch for the commanded time, then a release gap.
module keypad_emulator #(
  parameter int DEPTH      = 4,
  parameter int HOLD_W     = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  output logic              pressed,
  output logic [3:0]        cur_key,
  output logic              busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t             state, state_n;
  logic [3:0]         key_mem  [DEPTH];
  logic [HOLD_W-1:0]  hold_mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, empty, push, pop;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [3:0]         key_r;
  logic [HOLD_W-1:0]  head_hold;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head_hold = hold_mem[rd_ptr];

  // FIFO storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      key_mem[wr_ptr]  <= cmd_key;
      hold_mem[wr_ptr] <= cmd_hold;
    end
    if (pop) key_r <= key_mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE:  if (pop) hold_cnt <= (head_hold == '0) ? HOLD_W'(1) : head_hold;
        PRESS: begin
          hold_cnt <= hold_cnt - 1'b1;
          if (hold_cnt == HOLD_W'(1)) gap_cnt <= GAP_LD;
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!empty) state_n = PRESS;
      PRESS:   if (hold_cnt == HOLD_W'(1)) state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (gap_cnt == GAP_W'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Column response is combinational so the scanner sees it in the same cycle.
  always_comb begin
    pressed = (state == PRESS) && !rst;
    cur_key = 4'd0;
    col_out = 4'd0;
    busy    = (state != IDLE) || !empty;
    if (pressed) begin
      cur_key = key_r;
      if (row_in[key_r[3:2]]) col_out = 4'b0001 << key_r[1:0];
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one instance with an 8-cycle gap, one with no gap.
module tb_keypad_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, pressed, busy;
  logic [3:0]  cmd_key, row_in, col_out, cur_key;
  logic [15:0] cmd_hold;
  logic        g0_cmd_valid, g0_cmd_ready, g0_pressed, g0_busy;
  logic [3:0]  g0_cmd_key, g0_row_in, g0_col_out, g0_cur_key;
  logic [15:0] g0_cmd_hold;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp3 [15] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h0, 4'h0, 4'hD, 4'hD, 4'hD, 4'h0};
  logic [3:0] exp4 [5]  = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
  logic [3:0] rec  [$];

  always #5 clk = ~clk;

  keypad_emulator #(.DEPTH(4), .HOLD_W(16), .GAP_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_key(cmd_key), .cmd_hold(cmd_hold), .row_in(row_in), .col_out(col_out),
    .pressed(pressed), .cur_key(cur_key), .busy(busy)
  );

  keypad_emulator #(.DEPTH(4), .HOLD_W(16), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(g0_cmd_valid), .cmd_ready(g0_cmd_ready),
    .cmd_key(g0_cmd_key), .cmd_hold(g0_cmd_hold), .row_in(g0_row_in), .col_out(g0_col_out),
    .pressed(g0_pressed), .cur_key(g0_cur_key), .busy(g0_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int bad;
    logic prev;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_key = '0; cmd_hold = '0; row_in = '0;
    g0_cmd_valid = 1'b0; g0_cmd_key = '0; g0_cmd_hold = '0; g0_row_in = '0;
    repeat (2) tick();

    // Reset state and idle scanning
    chk("rst cmd_ready", 32'(cmd_ready), 0);
    chk("rst col_out", 32'(col_out), 0);
    chk("rst pressed", 32'(pressed), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst cur_key", 32'(cur_key), 0);
    chk("rst g0 cmd_ready", 32'(g0_cmd_ready), 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("idle cmd_ready", 32'(cmd_ready), 1);
    chk("idle busy", 32'(busy), 0);
    for (int r = 0; r < 4; r++) begin
      row_in = 4'(1 << r);
      #1 chk("idle col_out", 32'(col_out), 0);
    end

    // Single press: key 6 (row 1, col 2), hold 5
    row_in = 4'b0010;
    cmd_valid = 1'b1; cmd_key = 4'h6; cmd_hold = 16'd5;
    tick();
    cmd_valid = 1'b0;
    chk("t2 pushed pressed", 32'(pressed), 0);
    chk("t2 pushed busy", 32'(busy), 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("t2 pressed", 32'(pressed), 1);
      chk("t2 cur_key", 32'(cur_key), 32'h6);
      chk("t2 col_out row1", 32'(col_out), 32'h4);
      row_in = 4'b0001;
      #1 chk("t2 col_out row0", 32'(col_out), 0);
      row_in = 4'b0010;
    end
    tick();
    chk("t2 released", 32'(pressed), 0);
    chk("t2 released cur_key", 32'(cur_key), 0);
    chk("t2 gap busy", 32'(busy), 1);
    repeat (8) tick();
    chk("t2 gap done busy", 32'(busy), 0);

    // Gap and ordering: 0x3 hold 2 then 0xD hold 3
    cmd_valid = 1'b1; cmd_key = 4'h3; cmd_hold = 16'd2;
    tick();
    cmd_key = 4'hD; cmd_hold = 16'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t3 cur_key", 32'(cur_key), 32'(exp3[i]));
      chk("t3 pressed", 32'(pressed), 32'(exp3[i] != 4'h0));
      if (i < 14) tick();
    end
    repeat (8) tick();
    chk("t3 done busy", 32'(busy), 0);

    // Full FIFO with a long first press
    cmd_valid = 1'b1; cmd_key = 4'h1; cmd_hold = 16'd100;
    tick();
    for (int k = 2; k <= 5; k++) begin
      cmd_key = 4'(k); cmd_hold = 16'd3;
      tick();
    end
    chk("t4 full ready", 32'(cmd_ready), 0);
    chk("t4 first key", 32'(cur_key), 32'h1);
    cmd_key = 4'h6;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4 held off", 32'(cmd_ready), 0);
    end
    w = 0;
    while (!cmd_ready && w < 300) begin
      tick();
      w++;
    end
    chk("t4 ready wait cycles", 32'(w), 101);
    chk("t4 ready pressed key", 32'(cur_key), 32'h2);
    tick();
    cmd_valid = 1'b0;
    prev = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (pressed && !prev) rec.push_back(cur_key);
      prev = pressed;
      tick();
    end
    chk("t4 press count", 32'(rec.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < rec.size()) chk("t4 order", 32'(rec[i]), 32'(exp4[i]));
    chk("t4 done busy", 32'(busy), 0);

    // Hold zero, gap zero on the second instance
    g0_row_in = 4'b1000;
    g0_cmd_valid = 1'b1; g0_cmd_key = 4'hF; g0_cmd_hold = 16'd0;
    tick();
    g0_cmd_key = 4'h0; g0_cmd_hold = 16'd1;
    tick();
    g0_cmd_valid = 1'b0;
    chk("t5 F pressed", 32'(g0_pressed), 1);
    chk("t5 F cur_key", 32'(g0_cur_key), 32'hF);
    chk("t5 F col_out", 32'(g0_col_out), 32'h8);
    tick();
    chk("t5 gap pressed", 32'(g0_pressed), 0);
    chk("t5 gap col_out", 32'(g0_col_out), 0);
    tick();
    chk("t5 0 pressed", 32'(g0_pressed), 1);
    chk("t5 0 col_out row3", 32'(g0_col_out), 0);
    g0_row_in = 4'b0001;
    #1 chk("t5 0 col_out row0", 32'(g0_col_out), 32'h1);
    tick();
    chk("t5 end pressed", 32'(g0_pressed), 0);
    chk("t5 end busy", 32'(g0_busy), 0);

    // Reset mid-press with three commands queued
    row_in = 4'b0010;
    cmd_valid = 1'b1; cmd_key = 4'h5; cmd_hold = 16'd50;
    tick();
    for (int k = 1; k <= 3; k++) begin
      cmd_key = 4'(k); cmd_hold = 16'd5;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t6 pre pressed", 32'(pressed), 1);
    chk("t6 pre col_out", 32'(col_out), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst col_out", 32'(col_out), 0);
    chk("t6 rst pressed", 32'(pressed), 0);
    chk("t6 rst busy", 32'(busy), 0);
    chk("t6 rst cmd_ready", 32'(cmd_ready), 0);
    @(negedge clk) rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pressed || busy) bad++;
    end
    chk("t6 quiet after rst", 32'(bad), 0);
    cmd_valid = 1'b1; cmd_key = 4'h7; cmd_hold = 16'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t6 new press", 32'(pressed), 1);
    chk("t6 new key", 32'(cur_key), 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Behavioural model and stimulus source for the 4x4 matrix keypad interface: the column-driving end of the row-scan protocol.
- Accepts queued key-press commands (key code + hold time) over a valid/ready handshake.
- Closes the addressed row-to-column switch for the commanded number of clock cycles, then enforces a release gap.
- Used in place of the physical keypad in simulation and in board self-test builds of Pong.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
HOLD_W, 16, width of the per-command hold-cycle count
GAP_CYCLES, 8, cycles with all keys released between consecutive presses (0 allowed)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; transfer on cmd_valid && cmd_ready at rising edge
cmd_key  in  4  key code {row[1:0], col[1:0]}; row 0 = top row, col 0 = leftmost column
cmd_hold  in  HOLD_W  press duration in clk cycles; 0 treated as 1
row_in  in  4  row drive lines from scanner; row_in[r] high = row r driven
col_out  out  4  column sense lines to scanner; col_out[c] = column c
pressed  out  1  a key is currently closed
cur_key  out  4  code of closed key; 0 when not pressed
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty, FSM = IDLE, counters 0, pressed = 0, cur_key = 0, col_out = 0, busy = 0, cmd_ready = 0 while rst is high.
- FIFO:
  - Synchronous, DEPTH entries of {key, hold}, wrap-around pointers plus an occupancy count.
  - cmd_ready = !full && !rst.
  - Push and pop in the same cycle are legal at any occupancy below full; occupancy is unchanged.
  - No push is possible while full; cmd_valid is ignored.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load key, load hold counter = max(hold, 1), go to PRESS. Else stay.
  - PRESS: pressed = 1, cur_key = key. Decrement hold counter each cycle. When counter == 1 on an edge: if GAP_CYCLES > 0 go to GAP with gap counter = GAP_CYCLES, else go to IDLE.
  - GAP: pressed = 0, cur_key = 0. Decrement gap counter; when counter == 1 go to IDLE.
- Timing:
  - A command pushed at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1.
  - pressed is high from edge N+1 through edge N+1+hold, i.e. exactly hold cycles.
  - The next press begins GAP_CYCLES+1 cycles after release: GAP_CYCLES gap cycles plus one IDLE pop cycle.
  - With GAP_CYCLES = 0 the gap is one IDLE cycle.
- Column response (combinational, zero latency, so the scanner samples in the same cycle it drives a row):
  - col_out[c] = pressed && (c == key[1:0]) && row_in[key[3:2]].
  - All other columns are 0.
  - Multiple rows driven simultaneously: only the pressed key's row is considered.
  - Output with no row driven is 0.
- Reset mid-press: col_out drops to 0 combinationally with rst; the queued commands are discarded.
- busy = (state != IDLE) || !empty.

Test Plan:
- Reset then idle: rst pulse, row_in cycling 0001->0010->0100->1000 -> col_out = 0000, pressed = 0, cmd_ready = 1 after rst release, busy = 0.
- Single press: push key 4'b0110 (row 1, col 2) with hold = 5 at edge N, row_in = 0010 -> pressed and col_out = 0100 for edges N+1..N+5. With row_in = 0001 during the same window, col_out = 0000. pressed = 0 at edge N+6.
- Gap and ordering: GAP_CYCLES = 8; push keys 0x3 (hold 2) then 0xD (hold 3) back to back -> 0x3 pressed 2 cycles, 8 gap cycles, 1 IDLE cycle, then 0xD pressed 3 cycles. cur_key shows 0x3 then 0xD.
- Full FIFO: hold = 100; push DEPTH+1 commands while the first is pressed -> after the first pops, DEPTH more are accepted; cmd_ready drops to 0 at full; the extra command is held off until the next pop. No entry is lost or duplicated.
- Hold zero and gap zero: build with GAP_CYCLES = 0; push key 0xF with hold = 0, then 0x0 with hold = 1 -> each is pressed exactly 1 cycle, separated by exactly 1 released cycle. With row_in = 1000 during 0xF, col_out = 1000.
- Reset mid-operation: 3 queued commands plus an active press of 0x5; assert rst asynchronously between edges -> col_out and pressed go to 0 immediately, FIFO is empty, and no press occurs after rst release until a new push.
